tt_um_sharjeel_regbus_responder: RTL

- Tiny Tapeout user macro: pin-level, 4-phase req/ack register-bus responder.
- An off-chip host (in simulation, the cocotb bench) issues commands on ui_in and exchanges data over the bidirectional uio bus.
- Holds an 8 x 8-bit register file; supports write, read, add-accumulate and clear.

---
 rtl/tt_um_sharjeel_regbus_responder.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/tt_um_sharjeel_regbus_responder.sv
// 4-phase req/ack register-bus responder: 8 x 8-bit register file with write/read/add/clear.
// Optional even-parity check on WRITE/ADD operands is built when SHARJEEL_PARITY_EN is defined.
module tt_um_sharjeel_regbus_responder #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter logic [7:0]  REG_RESET_VALUE = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // Handshake: the host raises req with cmd/addr/operand stable; we answer with ack
  // and keep it high until req drops. Read data is driven on uio only while ack=1.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_WRITE = 3'd1;
  localparam logic [2:0] CMD_READ  = 3'd2;
  localparam logic [2:0] CMD_ADD   = 3'd3;
  localparam logic [2:0] CMD_CLEAR = 3'd4;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_armed;
  logic [7:0]             r_regs [8];
  logic [7:0]             r_rd_buf;
  logic                   r_rd_valid;
  logic                   r_err;
  logic                   r_carry;
  logic [3:0]             r_txn_count;

  logic                   w_req_s;
  logic [2:0]             w_cmd;
  logic [2:0]             w_addr;
  logic [8:0]             w_sum;
  logic                   w_parity_ok;
  logic                   w_ack;
  logic                   w_busy;

  assign w_req_s = r_sync[SYNC_STAGES-1];
  assign w_cmd   = ui_in[2:0];
  assign w_addr  = ui_in[5:3];
  assign w_sum   = {1'b0, r_regs[w_addr]} + {1'b0, uio_in};

`ifdef SHARJEEL_PARITY_EN
  assign w_parity_ok = (ui_in[6] == ^uio_in);
`else
  logic w_unused;
  assign w_parity_ok = 1'b1;
  assign w_unused    = ui_in[6];
`endif

  // Synchronizer resets to all ones so a req held through reset reads as still high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], ui_in[7]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b0;
    end else if (!w_req_s) begin
      r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_req_s && r_armed && ena) w_next_state = S_EXEC;
      S_EXEC:  w_next_state = S_ACK;
      S_ACK:   if (!w_req_s) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_regs[i] <= REG_RESET_VALUE;
      r_rd_buf    <= 8'h00;
      r_rd_valid  <= 1'b0;
      r_err       <= 1'b0;
      r_carry     <= 1'b0;
      r_txn_count <= 4'd0;
    end else if (r_state == S_EXEC) begin
      r_txn_count <= r_txn_count + 4'd1;
      r_rd_valid  <= 1'b0;
      r_err       <= 1'b0;
      case (w_cmd)
        CMD_NOP: ;
        CMD_WRITE: begin
          if (w_parity_ok) r_regs[w_addr] <= uio_in;
          else             r_err          <= 1'b1;
        end
        CMD_READ: begin
          r_rd_buf   <= r_regs[w_addr];
          r_rd_valid <= 1'b1;
        end
        CMD_ADD: begin
          if (w_parity_ok) begin
            r_regs[w_addr] <= w_sum[7:0];
            r_carry        <= w_sum[8];
          end else begin
            r_err <= 1'b1;
          end
        end
        CMD_CLEAR: begin
          for (int i = 0; i < 8; i++) r_regs[i] <= REG_RESET_VALUE;
        end
        default: r_err <= 1'b1;
      endcase
    end
  end

  // Bus drive is decoded from state, so it drops with ack and asynchronously on reset.
  assign w_ack   = (r_state == S_ACK);
  assign w_busy  = (r_state != S_IDLE);
  assign uo_out  = {w_ack, w_busy, r_err, r_carry, r_txn_count};
  assign uio_oe  = (w_ack && r_rd_valid) ? 8'hFF : 8'h00;
  assign uio_out = (w_ack && r_rd_valid) ? r_rd_buf : 8'h00;

endmodule
